// File: rtl/pipe_mem_arbiter_pkg.sv
// Shared definitions for the pipeline memory arbiter: state encoding, default
// bus widths and the performance counter width.
package pipe_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        IFETCH = 2'd2
    } arb_state_e;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int PERF_W     = 32;

    // Saturating increment: the all-ones value is sticky.
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] val);
        return (val == {PERF_W{1'b1}}) ? val : (val + {{(PERF_W-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/pipe_mem_arbiter_if.sv
// Bus bundle between the pipeline stages, the arbiter and the shared memory.
// The slave modport is the arbiter's view, the master modport the environment's.
interface pipe_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_rdata, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_rdata, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/pipe_mem_arbiter_sat_counter.sv
// Saturating event counter with enable; holds at all-ones once reached.
module pipe_sat_counter
    import pipe_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    output logic [PERF_W-1:0] count
);
    logic [PERF_W-1:0] count_r;

    // Count enabled cycles, sticking at the maximum value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= {PERF_W{1'b0}};
        end else if (en) begin
            count_r <= sat_inc(count_r);
        end
    end

    assign count = count_r;
endmodule

// File: rtl/pipe_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store and
// raises pipe_stall until every access of the current cycle has completed.
// Optional macro PIPE_ARB_PERF_EN adds stall/grant performance counters.
module pipe_mem_arbiter
    import pipe_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    pipe_mem_arbiter_if.slave bus,
`ifdef PIPE_ARB_PERF_EN
    output logic [PERF_W-1:0] perf_stall_cycles,
    output logic [PERF_W-1:0] perf_if_grants,
    output logic [PERF_W-1:0] perf_d_grants,
`endif
    output logic              pipe_stall
);
    arb_state_e        state_r, next_state_s;
    logic              if_done_r, d_done_r;
    logic [DATA_W-1:0] if_rdata_r, d_rdata_r;
    logic              mem_req_r, mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              d_pend_s, if_pend_s, d_cmpl_s, if_cmpl_s, stall_s;
    logic              load_d_s, load_if_s, clr_req_s;

    // Pending work, completions, stall and the arbitration decision.
    always_comb begin
        d_pend_s     = bus.d_req & ~d_done_r;
        if_pend_s    = bus.if_req & ~if_done_r;
        d_cmpl_s     = (state_r == DATA) & bus.mem_ready;
        if_cmpl_s    = (state_r == IFETCH) & bus.mem_ready;
        stall_s      = (d_pend_s & ~d_cmpl_s) | (if_pend_s & ~if_cmpl_s);
        load_d_s     = 1'b0;
        load_if_s    = 1'b0;
        clr_req_s    = 1'b0;
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (d_pend_s) begin
                    load_d_s = 1'b1;
                end else if (if_pend_s) begin
                    load_if_s = 1'b1;
                end else begin
                    clr_req_s = 1'b0;
                end
            end
            DATA: begin
                if (!bus.mem_ready) begin
                    clr_req_s = 1'b0;
                end else if (if_pend_s) begin
                    load_if_s = 1'b1;
                end else begin
                    clr_req_s = 1'b1;
                end
            end
            IFETCH: begin
                if (!bus.mem_ready) begin
                    clr_req_s = 1'b0;
                end else if (d_pend_s) begin
                    load_d_s = 1'b1;
                end else begin
                    clr_req_s = 1'b1;
                end
            end
            default: begin
                clr_req_s = 1'b1;
            end
        endcase
        if (load_d_s) begin
            next_state_s = DATA;
        end else if (load_if_s) begin
            next_state_s = IFETCH;
        end else if (clr_req_s) begin
            next_state_s = IDLE;
        end else begin
            next_state_s = state_r;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered memory request; fields stay stable while a request is open.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
        end else if (load_d_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= bus.d_we;
            mem_addr_r  <= bus.d_addr;
            mem_wdata_r <= bus.d_wdata;
        end else if (load_if_s) begin
            mem_req_r  <= 1'b1;
            mem_we_r   <= 1'b0;
            mem_addr_r <= bus.if_addr;
        end else if (clr_req_s) begin
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
        end
    end

    // Done flags survive a stall and clear when the pipeline advances.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            d_done_r  <= 1'b0;
            if_done_r <= 1'b0;
        end else if (!stall_s) begin
            d_done_r  <= 1'b0;
            if_done_r <= 1'b0;
        end else begin
            if (d_cmpl_s)  d_done_r  <= 1'b1;
            if (if_cmpl_s) if_done_r <= 1'b1;
        end
    end

    // Read data capture, held for the remainder of the stall.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            d_rdata_r  <= {DATA_W{1'b0}};
            if_rdata_r <= {DATA_W{1'b0}};
        end else begin
            if (d_cmpl_s && !mem_we_r) d_rdata_r  <= bus.mem_rdata;
            if (if_cmpl_s)             if_rdata_r <= bus.mem_rdata;
        end
    end

    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.d_rdata   = d_cmpl_s  ? bus.mem_rdata : d_rdata_r;
    assign bus.if_rdata  = if_cmpl_s ? bus.mem_rdata : if_rdata_r;
    assign pipe_stall    = stall_s;

`ifdef PIPE_ARB_PERF_EN
    pipe_sat_counter u_stall_cnt (.clock(clock), .reset(reset), .en(stall_s),   .count(perf_stall_cycles));
    pipe_sat_counter u_if_cnt    (.clock(clock), .reset(reset), .en(if_cmpl_s), .count(perf_if_grants));
    pipe_sat_counter u_d_cnt     (.clock(clock), .reset(reset), .en(d_cmpl_s),  .count(perf_d_grants));
`endif
endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed self-checking bench for pipe_mem_arbiter; the bench drives both the
// pipeline requests and the memory responses cycle by cycle.
module tb_pipe_mem_arbiter;
    import pipe_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic pipe_stall;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   stalls;
`ifdef PIPE_ARB_PERF_EN
    logic [31:0] perf_stall_cycles, perf_if_grants, perf_d_grants;
`endif

    pipe_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    pipe_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus),
`ifdef PIPE_ARB_PERF_EN
        .perf_stall_cycles(perf_stall_cycles),
        .perf_if_grants(perf_if_grants),
        .perf_d_grants(perf_d_grants),
`endif
        .pipe_stall(pipe_stall)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
        if (pipe_stall) stalls++;
    endtask

    task automatic idle_inputs();
        bus.if_req = 1'b0; bus.if_addr = 32'h0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        bus.d_addr = 32'h0; bus.d_wdata = 32'h0; bus.mem_rdata = 32'h0; bus.mem_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        // Reset state
        #12;
        @(negedge clock);
        check_eq("rst_mem_req",   {31'd0, bus.mem_req}, 32'd0);
        check_eq("rst_mem_we",    {31'd0, bus.mem_we}, 32'd0);
        check_eq("rst_mem_addr",  bus.mem_addr, 32'h0);
        check_eq("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check_eq("rst_d_rdata",   bus.d_rdata, 32'h0);
        check_eq("rst_if_rdata",  bus.if_rdata, 32'h0);
        check_eq("rst_stall",     {31'd0, pipe_stall}, 32'd0);
        reset = 1'b1;

        // Reset dropped while a load is in flight
        next_cyc();
        bus.d_req = 1'b1; bus.d_addr = 32'h100;
        @(negedge clock);
        check_eq("rmid_issue_lat", {31'd0, bus.mem_req}, 32'd0);
        check_eq("rmid_stall0",    {31'd0, pipe_stall}, 32'd1);
        next_cyc();
        @(negedge clock);
        check_eq("rmid_req_up",  {31'd0, bus.mem_req}, 32'd1);
        check_eq("rmid_addr",    bus.mem_addr, 32'h100);
        #2 reset = 1'b0;
        #1;
        check_eq("rmid_req_drop", {31'd0, bus.mem_req}, 32'd0);
        check_eq("rmid_stall_d",  {31'd0, pipe_stall}, 32'd1);
        bus.d_req = 1'b0; bus.if_req = 1'b1;
        #1 check_eq("rmid_stall_if", {31'd0, pipe_stall}, 32'd1);
        bus.if_req = 1'b0;
        #1 check_eq("rmid_stall_none", {31'd0, pipe_stall}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Fetch only, single-cycle memory
        next_cyc();
        stalls = 0;
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        sample();
        check_eq("f_issue_lat", {31'd0, bus.mem_req}, 32'd0);
        next_cyc();
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h8C010004;
        sample();
        check_eq("f_mem_req",  {31'd0, bus.mem_req}, 32'd1);
        check_eq("f_mem_addr", bus.mem_addr, 32'h40);
        check_eq("f_mem_we",   {31'd0, bus.mem_we}, 32'd0);
        check_eq("f_if_rdata", bus.if_rdata, 32'h8C010004);
        check_eq("f_stalls",   stalls, 32'd1);
        next_cyc();
        idle_inputs();
        @(negedge clock);
        check_eq("f_req_low",   {31'd0, bus.mem_req}, 32'd0);
        check_eq("f_rdata_hold", bus.if_rdata, 32'h8C010004);

        // Load plus fetch: data first, then fetch back-to-back
        next_cyc();
        stalls = 0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
        bus.if_req = 1'b1; bus.if_addr = 32'h44;
        sample();
        next_cyc();
        sample();
        check_eq("lf_data_first", bus.mem_addr, 32'h100);
        check_eq("lf_req_c1",     {31'd0, bus.mem_req}, 32'd1);
        next_cyc();
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        sample();
        check_eq("lf_d_bypass", bus.d_rdata, 32'hDEADBEEF);
        check_eq("lf_stall_c2", {31'd0, pipe_stall}, 32'd1);
        next_cyc();
        bus.mem_rdata = 32'h8C020008;
        sample();
        check_eq("lf_no_gap",   {31'd0, bus.mem_req}, 32'd1);
        check_eq("lf_if_addr",  bus.mem_addr, 32'h44);
        check_eq("lf_d_held",   bus.d_rdata, 32'hDEADBEEF);
        check_eq("lf_if_rdata", bus.if_rdata, 32'h8C020008);
        check_eq("lf_stalls",   stalls, 32'd3);
        next_cyc();
        idle_inputs();
        @(negedge clock);
        check_eq("lf_req_low", {31'd0, bus.mem_req}, 32'd0);

        // Store, 3-cycle latency, fetch waits until the store completes
        next_cyc();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200; bus.d_wdata = 32'h12345678;
        bus.if_req = 1'b1; bus.if_addr = 32'h48;
        @(negedge clock);
        for (int c = 1; c <= 3; c++) begin
            next_cyc();
            bus.mem_ready = (c == 3);
            @(negedge clock);
            check_eq($sformatf("st_we_c%0d", c),    {31'd0, bus.mem_we}, 32'd1);
            check_eq($sformatf("st_addr_c%0d", c),  bus.mem_addr, 32'h200);
            check_eq($sformatf("st_wdata_c%0d", c), bus.mem_wdata, 32'h12345678);
            check_eq($sformatf("st_stall_c%0d", c), {31'd0, pipe_stall}, 32'd1);
        end
        next_cyc();
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h8C03000C;
        @(negedge clock);
        check_eq("st_if_addr",  bus.mem_addr, 32'h48);
        check_eq("st_if_we",    {31'd0, bus.mem_we}, 32'd0);
        check_eq("st_stall_end", {31'd0, pipe_stall}, 32'd0);
        next_cyc();
        idle_inputs();

        // Two consecutive loads: the second is issued only after the first retires
        bus.d_req = 1'b1; bus.d_addr = 32'h100;
        @(negedge clock);
        next_cyc();
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h11111111;
        @(negedge clock);
        check_eq("ll_first_stall", {31'd0, pipe_stall}, 32'd0);
        check_eq("ll_first_data",  bus.d_rdata, 32'h11111111);
        next_cyc();
        bus.d_addr = 32'h104; bus.mem_ready = 1'b0;
        @(negedge clock);
        check_eq("ll_no_dup",    {31'd0, bus.mem_req}, 32'd0);
        check_eq("ll_re_stall",  {31'd0, pipe_stall}, 32'd1);
        next_cyc();
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h22222222;
        @(negedge clock);
        check_eq("ll_second_addr", bus.mem_addr, 32'h104);
        check_eq("ll_second_data", bus.d_rdata, 32'h22222222);
        check_eq("ll_second_stall", {31'd0, pipe_stall}, 32'd0);
        next_cyc();
        idle_inputs();

`ifdef PIPE_ARB_PERF_EN
        // Stall counter saturation
        force dut.u_stall_cnt.count_r = 32'hFFFFFFFE;
        #1 release dut.u_stall_cnt.count_r;
        bus.d_req = 1'b1; bus.d_addr = 32'h300;
        for (int c = 0; c < 5; c++) next_cyc();
        bus.mem_ready = 1'b1;
        next_cyc();
        idle_inputs();
        @(negedge clock);
        check_eq("perf_stall_sat", perf_stall_cycles, 32'hFFFFFFFF);
        check_eq("perf_if_grants", perf_if_grants, 32'd3);
        check_eq("perf_d_grants",  perf_d_grants, 32'd5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
